ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
// - AHB-Lite slave wrapping a parametrised synchronous SRAM; successor to the single-byte slave memory.
// - Adds bus-width data, HSIZE byte/halfword/word lanes, programmable wait states and alignment ERROR response.
// - Adds write-to-read forwarding. Sits behind the AHB-Lite decoder/mux as a generic memory slave.
// PARAMETERS
// - ADDR_WIDTH   10  byte-address bits decoded from HADDR; memory size = 2**ADDR_WIDTH bytes
// - DATA_WIDTH   32  HWDATA/HRDATA width; legal values 8, 16, 32, 64
// - WAIT_STATES  0   extra HREADYOUT-low cycles inserted in every OKAY data phase (0..15)
// PORTS
// - clk        in   1           bus clock (HCLK); all state on rising edge
// - HRESET     in   1           asynchronous, active-high reset
// - HSEL       in   1           slave select from decoder
// - HADDR      in   32          byte address; bits [ADDR_WIDTH-1:0] used
// - HWRITE     in   1           1 = write, 0 = read
// - HSIZE      in   3           0 = byte, 1 = half, 2 = word, 3 = dword
// - HTRANS     in   2           IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
// - HWDATA     in   DATA_WIDTH  write data, valid in data phase
// - HREADY     in   1           bus-wide ready (from mux)
// - HRDATA     out  DATA_WIDTH  read data
// - HREADYOUT  out  1           slave ready
// - HRESP      out  1           0 = OKAY, 1 = ERROR
// BEHAVIOUR
// - Reset: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0. Memory contents are not reset.
// - Accept: address phase accepted when HSEL & HREADY & HTRANS[1].
//   - Registers addr, write, size and the lane mask.
//   - IDLE/BUSY, or HSEL=0: no access; next data phase is zero-wait OKAY.
// - Illegal transfer: HSIZE > log2(DATA_WIDTH/8), or HADDR not aligned to 2**HSIZE.
//   - FSM goes to ERR1: HREADYOUT=0, HRESP=1.
//   - Then ERR2: HREADYOUT=1, HRESP=1.
//   - No memory write in either cycle.
// - Legal transfer: FSM enters WAIT if WAIT_STATES>0 (counter loaded), else DATA.
//   - WAIT: HREADYOUT=0, counter decrements; at 1 -> DATA.
//   - DATA: HREADYOUT=1, HRESP=0.
// - Lanes: little-endian. Active byte lanes = (2**HSIZE) bytes starting at HADDR[log2(DATA_WIDTH/8)-1:0].
// - Write: HWDATA lanes written at the rising edge ending the DATA cycle (HREADYOUT=1). Inactive lanes unchanged.
// - Read latency:
//   - Array read issued at address-phase accept, registered.
//   - HRDATA valid in the DATA cycle (1 cycle after accept when WAIT_STATES=0).
//   - Inactive lanes = 0. HRDATA = 0 whenever not completing a read; never Z.
// - Forwarding: a read accepted during the data phase of a write to the same word gets the write's active
//   lanes merged from HWDATA. Other lanes come from the array.
// - Back-to-back: a new address phase is accepted in the same cycle a DATA/ERR2 phase completes.
//   Pipelining continues with no idle cycle when WAIT_STATES=0.
// - Reset asserted mid-transfer (WAIT/DATA/ERR*): the transfer is aborted, no write occurs, outputs return
//   to reset values asynchronously.
// - Address wrap: HADDR bits above ADDR_WIDTH are ignored (aliasing). The top address is legal.
// STRUCTURE
// - Package ahb_lite_pkg holds:
//   - htrans_t, hsize_t and hresp enums
//   - HTRANS_IDLE/BUSY/NONSEQ/SEQ, RESP_OKAY/RESP_ERROR constants
//   - slv_state_t {IDLE, WAIT, DATA, ERR1, ERR2}
// - Sub-module sram_be_array: 2**ADDR_WIDTH/(DATA_WIDTH/8) words of DATA_WIDTH, per-byte write enable,
//   registered read port. Same clock; no reset.
// - Top level holds: address-phase registers, FSM, wait counter, lane decode, forwarding mux.
// TESTING
// - Word write/read: NONSEQ W 0x010 = 0xDEADBEEF, then NONSEQ R 0x010 -> HRDATA=0xDEADBEEF, HRESP=0, zero waits.
// - Byte lanes: byte W 0x013 = 0xAA over word 0x11223344 -> word R 0x010 = 0xAA223344.
//   Half R 0x012 -> 0xAA220000.
// - Forwarding: W 0x020 = 0xCAFEF00D immediately followed by R 0x020 (no idle) -> HRDATA = 0xCAFEF00D.
// - WAIT_STATES=2: W then R -> HREADYOUT low exactly 2 cycles per data phase; data correct.
// - Error: half R 0x011 and word W 0x002 -> two-cycle ERROR (HREADYOUT 0 then 1, HRESP=1).
//   Target word unchanged.
// - Reset in WAIT of a W 0x030 = 0x12345678 -> outputs at reset values same cycle.
//   Later R 0x030 shows the pre-reset content; no write occurred.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg: AHB-Lite transfer encodings, memory-slave FSM states and byte-lane helpers.
package ahb_lite_pkg;
    typedef enum logic [1:0] {HTRANS_IDLE = 2'd0, HTRANS_BUSY = 2'd1, HTRANS_NONSEQ = 2'd2, HTRANS_SEQ = 2'd3} htrans_t;
    typedef enum logic [2:0] {HSIZE_BYTE = 3'd0, HSIZE_HALF = 3'd1, HSIZE_WORD = 3'd2, HSIZE_DWORD = 3'd3} hsize_t;
    typedef enum logic {RESP_OKAY = 1'b0, RESP_ERROR = 1'b1} hresp_t;
    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} slv_state_t;

    function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] off);
        logic [7:0] m;
        m = (size == HSIZE_BYTE) ? 8'h01 : (size == HSIZE_HALF) ? 8'h03 : (size == HSIZE_WORD) ? 8'h0F : 8'hFF;
        return m << off;
    endfunction

    function automatic logic [2:0] align_mask(input logic [2:0] size);
        return (size == HSIZE_BYTE) ? 3'd0 : (size == HSIZE_HALF) ? 3'd1 : (size == HSIZE_WORD) ? 3'd3 : 3'd7;
    endfunction
endpackage

// File: rtl/sram_be_array.sv
// sram_be_array: single-clock word-wide SRAM with per-byte write enables and a registered,
// read-enabled output that holds its value between reads.
module sram_be_array #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic [DW/8-1:0] i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [DW-1:0]   i_wdata,
    input  logic            i_re,
    input  logic [AW-1:0]   i_raddr,
    output logic [DW-1:0]   o_rdata
);
    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int i = 0; i < DW / 8; i++)
            if (i_we[i]) r_mem[i_waddr][i*8 +: 8] <= i_wdata[i*8 +: 8];
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite memory slave with HSIZE byte lanes, programmable wait states,
// two-cycle alignment ERROR and write-to-read forwarding in front of a byte-enabled SRAM.
module ahb_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [1:0]            HTRANS,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int WW = ADDR_WIDTH - LB;

    slv_state_t            r_state, w_next;
    logic [3:0]            r_cnt;
    logic                  r_write;
    logic [NB-1:0]         r_be, r_fwd_be, w_mask, w_we;
    logic [WW-1:0]         r_widx, w_widx;
    logic [DATA_WIDTH-1:0] r_fwd_data, w_rdata, w_be_bits, w_fwd_bits;
    logic [2:0]            w_off;
    logic                  w_accept, w_legal, w_unused;

    assign w_accept = HSEL & HREADY & HTRANS[1];
    assign w_off    = HADDR[2:0] & 3'(NB - 1);
    assign w_widx   = HADDR[ADDR_WIDTH-1:LB];
    assign w_mask   = NB'(lane_mask(HSIZE, w_off));
    assign w_legal  = (HSIZE <= 3'(LB)) && ((HADDR[2:0] & align_mask(HSIZE)) == 3'd0);
    assign w_unused = &{1'b0, HADDR[31:ADDR_WIDTH], HTRANS[0]};
    assign w_we     = (r_state == DATA && r_write) ? r_be : '0;

    always_comb begin
        w_be_bits  = '0;
        w_fwd_bits = '0;
        for (int i = 0; i < NB; i++) begin
            w_be_bits[i*8 +: 8]  = {8{r_be[i]}};
            w_fwd_bits[i*8 +: 8] = {8{r_fwd_be[i]}};
        end
    end

    always_comb begin
        w_next    = r_state;
        HREADYOUT = !(r_state == WAIT || r_state == ERR1);
        HRESP     = (r_state == ERR1 || r_state == ERR2) ? RESP_ERROR : RESP_OKAY;
        HRDATA    = (r_state == DATA && !r_write)
                  ? (((w_fwd_bits & r_fwd_data) | (~w_fwd_bits & w_rdata)) & w_be_bits) : '0;
        if (r_state == WAIT) w_next = (r_cnt == 4'd1) ? DATA : WAIT;
        else if (r_state == ERR1) w_next = ERR2;
        else w_next = !w_accept ? IDLE : !w_legal ? ERR1 : (WAIT_STATES > 0) ? WAIT : DATA;
    end

    always_ff @(posedge clk or posedge HRESET) begin
        if (HRESET) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_be       <= '0;
            r_widx     <= '0;
            r_fwd_be   <= '0;
            r_fwd_data <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == WAIT) ? r_cnt - 4'd1 : 4'(WAIT_STATES);
            if (w_accept) begin
                r_write    <= HWRITE;
                r_be       <= w_mask;
                r_widx     <= w_widx;
                // a read overlapping a same-word write sees that write's lanes straight from HWDATA
                r_fwd_be   <= (r_state == DATA && r_write && r_widx == w_widx) ? r_be : '0;
                r_fwd_data <= HWDATA;
            end
        end
    end

    sram_be_array #(.AW(WW), .DW(DATA_WIDTH)) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_widx),
        .i_wdata (HWDATA),
        .i_re    (w_accept),
        .i_raddr (w_widx),
        .o_rdata (w_rdata)
    );
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: pipelined AHB-Lite master with a byte-level memory model feeding an
// expected-response queue; two slaves (0 and 2 wait states) share the bus behind HSEL.
module tb_ahb_sram_slave;
    typedef struct {
        logic        err;
        logic [31:0] data;
        int          waits;
        string       tag;
    } exp_t;

    logic        clk = 0;
    logic        rst0 = 1, rst2 = 1, sel = 0, hsel = 0, hwrite = 0;
    logic [31:0] haddr = 0, hwdata = 0, pend = 0;
    logic [2:0]  hsize = 0;
    logic [1:0]  htrans = 0;
    logic        hro0, hro2, hresp0, hresp2, hro, hresp, rst_cur;
    logic [31:0] hrd0, hrd2, hrd;
    logic [7:0]  mdl [2][1024];
    exp_t        q[$];
    int          n_chk = 0, n_fail = 0, wcnt = 0;
    bit          dp = 0;

    always #5 clk = ~clk;

    assign hro     = sel ? hro2 : hro0;
    assign hresp   = sel ? hresp2 : hresp0;
    assign hrd     = sel ? hrd2 : hrd0;
    assign rst_cur = sel ? rst2 : rst0;

    ahb_sram_slave dut0 (
        .clk(clk), .HRESET(rst0), .HSEL(hsel & ~sel), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HTRANS(htrans), .HWDATA(hwdata), .HREADY(hro0),
        .HRDATA(hrd0), .HREADYOUT(hro0), .HRESP(hresp0)
    );

    ahb_sram_slave #(.WAIT_STATES(2)) dut2 (
        .clk(clk), .HRESET(rst2), .HSEL(hsel & sel), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HTRANS(htrans), .HWDATA(hwdata), .HREADY(hro2),
        .HRDATA(hrd2), .HREADYOUT(hro2), .HRESP(hresp2)
    );

    // Scoreboard consumer: called once per cycle at the falling edge.
    task automatic observe();
        exp_t e;
        if (rst_cur) begin
            dp = 0;
            wcnt = 0;
            return;
        end
        if (dp) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_data_phase: HREADYOUT=%0b HRESP=%0b, expected no data phase", hro, hresp);
            end else if (!hro) begin
                wcnt++;
                if (hresp !== q[0].err || hrd !== 32'h0) begin
                    n_fail++;
                    $display("FAIL %s_wait: HRESP=%0b HRDATA=%h, expected HRESP=%0b HRDATA=0", q[0].tag, hresp, hrd, q[0].err);
                end
            end else begin
                e = q.pop_front();
                if (hresp !== e.err || hrd !== e.data || wcnt != e.waits) begin
                    n_fail++;
                    $display("FAIL %s: HRESP=%0b HRDATA=%h waits=%0d, expected HRESP=%0b HRDATA=%h waits=%0d",
                             e.tag, hresp, hrd, wcnt, e.err, e.data, e.waits);
                end
                wcnt = 0;
            end
        end else begin
            n_chk++;
            if (hro !== 1'b1 || hresp !== 1'b0 || hrd !== 32'h0) begin
                n_fail++;
                $display("FAIL idle_outputs: HREADYOUT=%0b HRESP=%0b HRDATA=%h, expected 1 0 0", hro, hresp, hrd);
            end
        end
        if (hro) dp = hsel && htrans[1];
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic step_until_ready();
        int n = 0;
        forever begin
            @(negedge clk);
            observe();
            if (hro) break;
            n++;
            if (n > 40) begin
                n_chk++;
                n_fail++;
                $display("FAIL timeout: HREADYOUT=0 for %0d cycles, expected 1", n);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd, input string tag);
        exp_t e;
        int nb;
        nb = 1 << sz;
        e.err = (sz > 3'd2) || ((a % nb) != 0);
        e.waits = e.err ? 1 : (sel ? 2 : 0);
        e.data = '0;
        e.tag = tag;
        if (!e.err)
            for (int i = 0; i < nb; i++) begin
                int b, l;
                b = int'((a + i) % 1024);
                l = int'((a + i) % 4);
                if (w) mdl[sel][b] = wd[l*8 +: 8];
                else e.data[l*8 +: 8] = mdl[sel][b];
            end
        q.push_back(e);
        hsel = 1;
        htrans = 2'd2;
        haddr = a;
        hwrite = w;
        hsize = sz;
        hwdata = pend;
        step_until_ready();
        pend = wd;
    endtask

    task automatic idle_cyc();
        hsel = 0;
        htrans = 2'd0;
        hwdata = pend;
        step_until_ready();
    endtask

    task automatic drain(input string tag);
        idle_cyc();
        idle_cyc();
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d responses outstanding, expected 0", tag, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        #1;
        n_chk++;
        if (hro0 !== 1'b1 || hresp0 !== 1'b0 || hrd0 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dut0: HREADYOUT=%0b HRESP=%0b HRDATA=%h, expected 1 0 0", hro0, hresp0, hrd0);
        end
        n_chk++;
        if (hro2 !== 1'b1 || hresp2 !== 1'b0 || hrd2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dut2: HREADYOUT=%0b HRESP=%0b HRDATA=%h, expected 1 0 0", hro2, hresp2, hrd2);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst0 = 0;
        rst2 = 0;
        tick();
    endtask

    task automatic test_word();
        sel = 0;
        issue(1, 3'd2, 32'h010, 32'hDEADBEEF, "word_w");
        issue(0, 3'd2, 32'h010, 32'h0, "word_r");
        drain("word");
    endtask

    task automatic test_lanes();
        sel = 0;
        issue(1, 3'd2, 32'h010, 32'h11223344, "lane_word_w");
        issue(1, 3'd0, 32'h013, 32'hAA000000, "lane_byte_w");
        issue(0, 3'd2, 32'h010, 32'h0, "lane_word_r");
        issue(0, 3'd1, 32'h012, 32'h0, "lane_half_r");
        issue(0, 3'd0, 32'h011, 32'h0, "lane_byte_r");
        drain("lanes");
    endtask

    task automatic test_forward();
        sel = 0;
        issue(1, 3'd2, 32'h020, 32'hCAFEF00D, "fwd_w");
        issue(0, 3'd2, 32'h020, 32'h0, "fwd_r");
        issue(1, 3'd2, 32'h024, 32'h01020304, "fwd_base_w");
        idle_cyc();
        issue(1, 3'd0, 32'h025, 32'h0000EE00, "fwd_byte_w");
        issue(0, 3'd2, 32'h024, 32'h0, "fwd_merge_r");
        drain("forward");
    endtask

    task automatic test_back_to_back();
        sel = 0;
        for (int i = 0; i < 6; i++) issue(1, 3'd2, 32'h100 + 32'(4 * i), $urandom, "b2b_w");
        for (int i = 0; i < 6; i++) issue(0, 3'd2, 32'h100 + 32'(4 * i), 32'h0, "b2b_r");
        for (int i = 0; i < 4; i++) issue(1, 3'd0, 32'h140 + 32'(i), 32'($urandom_range(255)) << (8 * i), "b2b_byte_w");
        issue(0, 3'd2, 32'h140, 32'h0, "b2b_bytes_r");
        issue(1, 3'd2, 32'h3FC, 32'h0BADF00D, "top_w");
        issue(0, 3'd2, 32'h7FC, 32'h0, "alias_r");
        drain("b2b");
    endtask

    task automatic test_error();
        sel = 0;
        issue(1, 3'd2, 32'h000, 32'h55667788, "err_pre_w");
        issue(0, 3'd1, 32'h011, 32'h0, "err_half_r");
        issue(1, 3'd2, 32'h002, 32'hFFFFFFFF, "err_word_w");
        issue(0, 3'd3, 32'h008, 32'h0, "err_dword_r");
        issue(0, 3'd2, 32'h000, 32'h0, "err_unchanged_r");
        drain("error");
    endtask

    task automatic test_waits();
        sel = 1;
        issue(1, 3'd2, 32'h040, 32'hA5A55A5A, "ws_w");
        issue(0, 3'd2, 32'h040, 32'h0, "ws_r");
        issue(1, 3'd1, 32'h042, 32'h77660000, "ws_half_w");
        issue(0, 3'd2, 32'h040, 32'h0, "ws_fwd_r");
        issue(0, 3'd1, 32'h041, 32'h0, "ws_err_r");
        drain("waits");
    endtask

    task automatic test_reset_abort();
        sel = 1;
        issue(1, 3'd2, 32'h030, 32'h11111111, "abort_pre_w");
        idle_cyc();
        hsel = 1;
        htrans = 2'd2;
        haddr = 32'h030;
        hwrite = 1;
        hsize = 3'd2;
        hwdata = pend;
        step_until_ready();
        hsel = 0;
        htrans = 2'd0;
        hwdata = 32'h12345678;
        n_chk++;
        if (hro2 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_in_wait: HREADYOUT=%0b, expected 0", hro2);
        end
        rst2 = 1;
        #1;
        n_chk++;
        if (hro2 !== 1'b1 || hresp2 !== 1'b0 || hrd2 !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_reset_outputs: HREADYOUT=%0b HRESP=%0b HRDATA=%h, expected 1 0 0", hro2, hresp2, hrd2);
        end
        tick();
        tick();
        rst2 = 0;
        tick();
        issue(0, 3'd2, 32'h030, 32'h0, "abort_post_r");
        drain("abort");
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_forward();
        test_back_to_back();
        test_error();
        test_waits();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
